// File: rtl/hazard_controller_pkg.sv
// Shared widths and FSM encoding for the pipeline hazard controller.
package hazard_controller_pkg;

  localparam int REG_ADDR_WIDTH   = 5;
  localparam int HC_CNT_WIDTH     = 32;
  localparam int HC_TIMEOUT_WIDTH = 16;

  typedef enum logic [1:0] {
    HC_RUN     = 2'd0,
    HC_MD_WAIT = 2'd1,
    HC_MD_HOLD = 2'd2
  } hc_state_e;

endpackage

// File: rtl/hazard_controller_load_use.sv
// Load-use detector: a load in EX writes a register the ID instruction reads.
module load_use_detector
  import hazard_controller_pkg::*;
#(
  parameter int addr_width = REG_ADDR_WIDTH
) (
  input  logic [addr_width-1:0] id_rs1,
  input  logic [addr_width-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [addr_width-1:0] ex_rd,
  input  logic                  ex_mem_read,
  output logic                  load_use
);

  // x0 never carries a real dependency, so a load into it needs no bubble.
  always_comb begin
    load_use = ex_mem_read && (ex_rd != '0) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                (id_uses_rs2 && (id_rs2 == ex_rd)));
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: stall/flush decisions, perf counters and
// a sticky data-memory timeout flag.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   HC_RUN     | normal flow; mul/div may start here
//   HC_MD_WAIT | mul/div busy, pipe front frozen, EX/MEM gets bubbles
//   HC_MD_HOLD | mul/div finished while MEM was waiting; release later
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int addr_width  = REG_ADDR_WIDTH,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_WIDTH   = HC_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [addr_width-1:0] id_rs1,
  input  logic [addr_width-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [addr_width-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_is_muldiv,
  input  logic                  branch_taken,
  input  logic                  muldiv_done,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  muldiv_start,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic [CNT_WIDTH-1:0]  stall_cycles,
  output logic [CNT_WIDTH-1:0]  flush_count,
  output logic                  mem_timeout
);

  hc_state_e state, state_nxt;
  logic      mem_wait, load_use, branch_win;
  logic      c_start, c_pc, c_if_id, c_id_ex, c_ex_mem, c_mem_wb;
  logic      c_if_id_fl, c_id_ex_fl, c_ex_mem_fl;
  logic [HC_TIMEOUT_WIDTH-1:0] to_cnt;
  logic [HC_TIMEOUT_WIDTH:0]   to_cnt_inc;

  assign mem_wait = dmem_req && !dmem_ready;

  load_use_detector #(.addr_width(addr_width)) u_load_use (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  // State register; reset also aborts any mul/div in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HC_RUN;
    else        state <= state_nxt;
  end

  // Priority resolution: MEM wait, mul/div, taken branch, load-use.
  always_comb begin
    state_nxt   = state;
    c_start     = 1'b0;
    c_pc        = 1'b1;
    c_if_id     = 1'b1;
    c_id_ex     = 1'b1;
    c_ex_mem    = 1'b1;
    c_mem_wb    = 1'b1;
    c_if_id_fl  = 1'b0;
    c_id_ex_fl  = 1'b0;
    c_ex_mem_fl = 1'b0;
    branch_win  = 1'b0;
    if (mem_wait) begin
      c_pc     = 1'b0;
      c_if_id  = 1'b0;
      c_id_ex  = 1'b0;
      c_ex_mem = 1'b0;
      c_mem_wb = 1'b0;
      if (state == HC_MD_WAIT && muldiv_done) state_nxt = HC_MD_HOLD;
    end else if (state == HC_RUN && ex_is_muldiv) begin
      c_start     = 1'b1;
      c_pc        = 1'b0;
      c_if_id     = 1'b0;
      c_id_ex     = 1'b0;
      c_ex_mem_fl = 1'b1;
      state_nxt   = HC_MD_WAIT;
    end else if (state == HC_MD_WAIT && !muldiv_done) begin
      c_pc        = 1'b0;
      c_if_id     = 1'b0;
      c_id_ex     = 1'b0;
      c_ex_mem_fl = 1'b1;
    end else begin
      // RUN, the done cycle, or an MD_HOLD release: the op leaves EX here.
      state_nxt = HC_RUN;
      if (branch_taken) begin
        c_if_id_fl = 1'b1;
        c_id_ex_fl = 1'b1;
        branch_win = 1'b1;
      end else if (load_use) begin
        c_pc       = 1'b0;
        c_if_id    = 1'b0;
        c_id_ex_fl = 1'b1;
      end
    end
  end

  // Outputs are held inactive for as long as reset is asserted.
  always_comb begin
    muldiv_start = rst_n && c_start;
    pc_en        = rst_n && c_pc;
    if_id_en     = rst_n && c_if_id;
    id_ex_en     = rst_n && c_id_ex;
    ex_mem_en    = rst_n && c_ex_mem;
    mem_wb_en    = rst_n && c_mem_wb;
    if_id_flush  = rst_n && c_if_id_fl;
    id_ex_flush  = rst_n && c_id_ex_fl;
    ex_mem_flush = rst_n && c_ex_mem_fl;
    to_cnt_inc   = {1'b0, to_cnt} + 1'b1;
  end

  // Perf counters wrap; the wait-run counter saturates so the flag cannot miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
      to_cnt       <= '0;
      mem_timeout  <= 1'b0;
    end else begin
      if (!c_pc)      stall_cycles <= stall_cycles + 1'b1;
      if (branch_win) flush_count  <= flush_count + 1'b1;
      if (mem_wait) begin
        if (to_cnt != '1) to_cnt <= to_cnt_inc[HC_TIMEOUT_WIDTH-1:0];
        if (to_cnt_inc >= (HC_TIMEOUT_WIDTH+1)'(MEM_TIMEOUT)) mem_timeout <= 1'b1;
      end else begin
        to_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: driver + reference model push
// expected outputs per cycle, a negedge monitor pops and compares.
module tb_hazard_controller;
  import hazard_controller_pkg::*;

  localparam int TO = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_uses_rs1 = 0, id_uses_rs2 = 0, ex_mem_read = 0, ex_is_muldiv = 0;
  logic branch_taken = 0, muldiv_done = 0, dmem_req = 0, dmem_ready = 0;
  logic muldiv_start, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_timeout;
  logic [CW-1:0] stall_cycles, flush_count;

  always #5 clk = ~clk;

  hazard_controller #(.addr_width(5), .MEM_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_is_muldiv(ex_is_muldiv),
    .branch_taken(branch_taken), .muldiv_done(muldiv_done),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .muldiv_start(muldiv_start), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .mem_timeout(mem_timeout)
  );

  typedef struct packed {
    logic [4:0] rs1, rs2;
    logic u1, u2;
    logic [4:0] rd;
    logic mr, md, br, done, req, rdy;
  } stim_t;

  typedef struct packed {
    logic start, pc, ifid, idex, exmem, memwb, fifid, fidex, fexmem, to;
    logic [CW-1:0] stalls, flushes;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0, n_bad = 0;

  // reference model: phase 0 = idle, 1 = mul/div busy, 2 = done but held by MEM
  int m_phase = 0, m_stalls = 0, m_flushes = 0, m_run = 0;
  bit m_to = 0, m_completed = 0, e_start = 0;

  // bench-side mul/div unit
  bit md_in_ex = 0;
  int md_k = 0, md_n = 1, wait_left = 0;

  exp_t mon_e, mon_a;
  stim_t s;

  function automatic exp_t dut_vec();
    exp_t a;
    a.start = muldiv_start; a.pc = pc_en; a.ifid = if_id_en; a.idex = id_ex_en;
    a.exmem = ex_mem_en; a.memwb = mem_wb_en; a.fifid = if_id_flush;
    a.fidex = id_ex_flush; a.fexmem = ex_mem_flush; a.to = mem_timeout;
    a.stalls = stall_cycles; a.flushes = flush_count;
    return a;
  endfunction

  task automatic model_step(input stim_t st, output exp_t e);
    bit mw, lu, br_win;
    int nxt;
    mw = st.req && !st.rdy;
    lu = st.mr && (st.rd != 0) && ((st.u1 && st.rs1 == st.rd) || (st.u2 && st.rs2 == st.rd));
    br_win = 0;
    nxt = m_phase;
    e = '0;
    e.pc = 1; e.ifid = 1; e.idex = 1; e.exmem = 1; e.memwb = 1;
    e.stalls = CW'(m_stalls); e.flushes = CW'(m_flushes); e.to = m_to;
    if (mw) begin
      e.pc = 0; e.ifid = 0; e.idex = 0; e.exmem = 0; e.memwb = 0;
      if (m_phase == 1 && st.done) nxt = 2;
    end else if (m_phase == 0 && st.md) begin
      e.start = 1; e.pc = 0; e.ifid = 0; e.idex = 0; e.fexmem = 1;
      nxt = 1;
    end else if (m_phase == 1 && !st.done) begin
      e.pc = 0; e.ifid = 0; e.idex = 0; e.fexmem = 1;
    end else begin
      nxt = 0;
      if (st.br) begin
        e.fifid = 1; e.fidex = 1; br_win = 1;
      end else if (lu) begin
        e.pc = 0; e.ifid = 0; e.fidex = 1;
      end
    end
    if (!e.pc)  m_stalls  = (m_stalls + 1) % (1 << CW);
    if (br_win) m_flushes = (m_flushes + 1) % (1 << CW);
    if (mw) m_run = m_run + 1; else m_run = 0;
    if (m_run >= TO) m_to = 1;
    m_completed = (m_phase != 0) && (nxt == 0);
    m_phase = nxt;
  endtask

  task automatic apply(input stim_t st);
    id_rs1 = st.rs1; id_rs2 = st.rs2; id_uses_rs1 = st.u1; id_uses_rs2 = st.u2;
    ex_rd = st.rd; ex_mem_read = st.mr; ex_is_muldiv = st.md; branch_taken = st.br;
    muldiv_done = st.done; dmem_req = st.req; dmem_ready = st.rdy;
  endtask

  task automatic drive_cycle(input stim_t st);
    exp_t e;
    @(posedge clk);
    #1;
    apply(st);
    model_step(st, e);
    e_start = e.start;
    q.push_back(e);
  endtask

  task automatic check_zero(input string name);
    exp_t a;
    a = dut_vec();
    n_cmp++;
    if (a !== '0) begin
      n_bad++;
      $display("FAIL %s: got %h want 0", name, a);
    end
  endtask

  task automatic do_reset(input string name);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    apply('0);
    #1;
    check_zero(name);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_phase = 0; m_stalls = 0; m_flushes = 0; m_run = 0; m_to = 0;
    md_in_ex = 0; wait_left = 0;
  endtask

  task automatic rand_cycle();
    stim_t st;
    st = '0;
    if (wait_left == 0 && $urandom_range(0, 99) < 10) wait_left = $urandom_range(1, 7);
    if (wait_left > 0) begin
      st.req = 1; st.rdy = 0; wait_left--;
    end else begin
      st.req = ($urandom_range(0, 3) == 0); st.rdy = 1;
    end
    if (m_phase == 0 && !md_in_ex && $urandom_range(0, 9) == 0) md_in_ex = 1;
    if (md_in_ex) begin
      st.md = 1;
      if (m_phase == 1) begin
        md_k++;
        st.done = (md_k >= md_n);
      end
    end else begin
      st.br  = ($urandom_range(0, 4) == 0);
      st.mr  = ($urandom_range(0, 2) == 0);
      st.rd  = 5'($urandom_range(0, 3));
      st.rs1 = 5'($urandom_range(0, 3));
      st.rs2 = 5'($urandom_range(0, 3));
      st.u1  = 1'($urandom_range(0, 1));
      st.u2  = 1'($urandom_range(0, 1));
    end
    drive_cycle(st);
    if (e_start) begin
      md_k = 0;
      md_n = $urandom_range(1, 5);
    end
    if (m_completed) md_in_ex = 0;
  endtask

  // monitor: every queued expectation is checked on the falling edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      mon_a = dut_vec();
      n_cmp++;
      if (mon_a !== mon_e) begin
        n_bad++;
        $display("FAIL outputs #%0d: got %h want %h (t=%0t)", n_cmp, mon_a, mon_e, $time);
      end
    end
  end

  initial begin
    #2;
    check_zero("reset_outputs");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // load-use on rs1, then the same with a load into x0
    s = '0; s.mr = 1; s.rd = 5; s.rs1 = 5; s.rs2 = 7; s.u1 = 1; s.u2 = 1;
    drive_cycle(s);
    drive_cycle('0);
    s.rd = 0; s.rs1 = 0;
    drive_cycle(s);
    // load-use on rs2 only
    s = '0; s.mr = 1; s.rd = 9; s.rs2 = 9; s.u2 = 1;
    drive_cycle(s);
    // branch together with a load-use
    s.br = 1;
    drive_cycle(s);
    drive_cycle('0);

    // mul/div, done four cycles after start
    s = '0; s.md = 1;
    repeat (4) drive_cycle(s);
    s.done = 1;
    drive_cycle(s);
    drive_cycle('0);

    // mul/div done during a three-cycle MEM wait
    s = '0; s.md = 1;
    drive_cycle(s);
    drive_cycle(s);
    s.req = 1; s.done = 1;
    drive_cycle(s);
    s.done = 0;
    drive_cycle(s);
    drive_cycle(s);
    s.rdy = 1;
    drive_cycle(s);
    drive_cycle('0);

    // timeout: six wait cycles, then ready, flag must stick
    do_reset("reset_before_timeout");
    s = '0; s.req = 1;
    repeat (6) drive_cycle(s);
    s.rdy = 1;
    drive_cycle(s);
    drive_cycle('0);
    drive_cycle('0);
    do_reset("reset_clears_timeout");
    drive_cycle('0);

    // asynchronous reset in the middle of MD_WAIT
    s = '0; s.md = 1;
    drive_cycle(s);
    drive_cycle(s);
    @(posedge clk);
    #1;
    apply(s);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset_mid_md");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply('0);
    m_phase = 0; m_stalls = 0; m_flushes = 0; m_run = 0; m_to = 0;
    drive_cycle('0);
    s = '0; s.br = 1;
    drive_cycle(s);

    // randomized segments separated by resets
    for (int seg = 0; seg < 3; seg++) begin
      do_reset("reset_segment");
      for (int i = 0; i < 800; i++) rand_cycle();
    end

    repeat (2) @(posedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drained: got %0d left want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
